key_debounce_array: RTL and testbench
=====================================

# key_debounce_array

Parametrised N-channel key front end. Each raw button input is synchronised, sampled on a shared slow tick, and debounced by a consecutive-sample filter. The block emits a registered debounced level plus one-cycle press/release pulses, with optional typematic auto-repeat. It sits between the board push-buttons and the game/control logic, and replaces the fixed four-key edge detector with a generic, configurable block.

## Interface
- N_KEYS, 4, number of independent key channels
- SAMPLE_DIV, 50000, CLK_50M cycles per sample tick (1 ms at 50 MHz); legal ≥2
- STABLE_CNT, 4, consecutive differing samples needed to accept a level change; legal ≥1
- ACTIVE_LOW, 0, 1 = raw input reads 0 when pressed
- REPEAT_EN, 1, 1 = auto-repeat enabled
- REPEAT_DELAY, 500, samples from accepted press to first repeat; legal ≥1
- REPEAT_RATE, 100, samples between subsequent repeats; legal ≥1

Ports:
- CLK_50M  in  1  system clock
- RSTn  in  1  reset, asynchronous, active-low
- key_in  in  N_KEYS  raw asynchronous button levels
- key_state  out  N_KEYS  debounced level, 1 = pressed
- key_press  out  N_KEYS  1-cycle pulse on accepted press and on each repeat
- key_repeat  out  N_KEYS  1-cycle pulse, asserted with key_press only for repeat events
- key_release  out  N_KEYS  1-cycle pulse on accepted release
- sample_tick  out  1  1-cycle pulse each sample instant (debug/shared timebase)

## Operation
- Synchroniser: 2-flop chain per channel. If ACTIVE_LOW=1, the input is inverted after the synchroniser, so internal sense is always 1 = pressed.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. sample_tick is registered and high in the cycle after the count equals SAMPLE_DIV-1.
- Debounce (per channel, evaluated only on tick cycles):
  - Counter width $clog2(STABLE_CNT+1).
  - Sample ≠ key_state: counter increments. When it reaches STABLE_CNT, key_state toggles, the counter clears, and a press or release pulse is emitted.
  - Sample = key_state: counter clears. A single bounce therefore restarts qualification.
- Repeat FSM (per channel), states IDLE, DELAY, REPEAT; repeat counter width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - IDLE → DELAY on accepted press; counter cleared.
  - DELAY: counter increments on each tick. When it reaches REPEAT_DELAY: pulse key_press and key_repeat, counter cleared, go to REPEAT.
  - REPEAT: same behaviour, with threshold REPEAT_RATE; stays in REPEAT.
  - Any state → IDLE on accepted release; no repeat is emitted in that cycle.
  - REPEAT_EN=0: the FSM stays in IDLE; key_repeat is constant 0.
- Channels are fully independent. Any combination of channels may pulse in the same cycle.
- key_press and key_release are never both high on one channel in the same cycle.

## Timing
- Reset (async assert): all outputs 0, key_state all 0, synchronisers, tick counter, debounce and repeat counters 0, FSMs in IDLE. Reset asserted mid-qualification or mid-repeat discards all progress.
- After RSTn deassert, the released state is assumed. A key held through reset produces key_press after STABLE_CNT ticks. No pulse is generated by reset itself.
- Latency: a clean edge on key_in produces a pulse 2 sync cycles plus STABLE_CNT ticks later (the first qualifying tick is the first tick after the value is synchronised), plus 1 register cycle. key_state changes in the same cycle as the pulse.
- All pulses last exactly 1 CLK_50M cycle, aligned with sample_tick.
- Press-and-hold, measured from the initial key_press: first repeat at REPEAT_DELAY ticks, then one every REPEAT_RATE ticks.
- Tick counter wraps without a gap: tick period is exactly SAMPLE_DIV cycles.

## Test plan
Bench parameters: N_KEYS=4, SAMPLE_DIV=10, STABLE_CNT=3, REPEAT_DELAY=5, REPEAT_RATE=2.

1. Reset, hold all key_in=0 for 200 cycles → every output 0, and sample_tick pulses every 10 cycles.
2. Clean press on key_in[0], held 40 cycles → exactly one key_press[0] on the 3rd tick after sync, key_state[0]=1 from the same cycle, and no other channel activity.
3. Bounce key_in[1] as 1 for 2 ticks, 0 for 1 tick, then steady 1 → no pulse until 3 consecutive high ticks, then a single key_press[1].
4. Hold key_in[2] for 12 ticks → key_press[2] at tick 3; repeats (key_press and key_repeat both high) at ticks 8, 10, 12, 14. Release → key_release[2] after 3 low ticks and no further repeats.
5. Press key_in[0] and key_in[3] simultaneously with ACTIVE_LOW=1 variant (inputs driven 1→0) → key_press[0] and key_press[3] in the same cycle.
6. Assert RSTn low while key_in[1] is held in the REPEAT state, then release reset with the key still held → all outputs 0 during reset, then a fresh key_press[1] after 3 ticks, with the first repeat 5 ticks after that.

Source files
------------

// File: rtl/key_debounce_array.sv
// N-channel push-button front end: 2-flop sync, shared sample tick, consecutive-sample
// debounce, registered level plus press/release/repeat pulses aligned with sample_tick.
module key_debounce_array #(
  parameter int N_KEYS       = 4,
  parameter int SAMPLE_DIV   = 50000,
  parameter int STABLE_CNT   = 4,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic              CLK_50M,
  input  logic              RSTn,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_repeat,
  output logic [N_KEYS-1:0] key_release,
  output logic              sample_tick
);

  localparam int TW   = $clog2(SAMPLE_DIV);
  localparam int SW   = $clog2(STABLE_CNT + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  logic [N_KEYS-1:0] sync1, sync2, key_sense;
  logic [TW-1:0]     tick_cnt;
  logic              tick_en;

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_sense = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Debounce and repeat logic run in the last cycle of each tick period, so their
  // registered pulses land in the same cycle as sample_tick.
  assign tick_en = (tick_cnt == TW'(SAMPLE_DIV - 1));

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else begin
      tick_cnt    <= tick_en ? '0 : tick_cnt + TW'(1);
      sample_tick <= tick_en;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    logic [SW-1:0] db_cnt, db_next;
    logic [RW-1:0] rpt_cnt, rpt_next, rpt_thr;
    rpt_state_t    rpt_st;
    logic          state_q, press_q, rpt_q, rel_q;
    logic          accept, acc_press, acc_rel;

    assign db_next   = db_cnt + SW'(1);
    assign accept    = tick_en && (key_sense[g] != state_q) && (db_next == SW'(STABLE_CNT));
    assign acc_press = accept && !state_q;
    assign acc_rel   = accept && state_q;
    assign rpt_next  = rpt_cnt + RW'(1);
    assign rpt_thr   = (rpt_st == DELAY) ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);

    always_ff @(posedge CLK_50M or negedge RSTn) begin
      if (!RSTn) begin
        db_cnt  <= '0;
        rpt_cnt <= '0;
        rpt_st  <= IDLE;
        state_q <= 1'b0;
        press_q <= 1'b0;
        rpt_q   <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rpt_q   <= 1'b0;
        rel_q   <= 1'b0;
        if (tick_en) begin
          if (key_sense[g] == state_q) begin
            db_cnt <= '0;
          end else if (accept) begin
            db_cnt  <= '0;
            state_q <= ~state_q;
            press_q <= acc_press;
            rel_q   <= acc_rel;
          end else begin
            db_cnt <= db_next;
          end

          // Release wins over a repeat falling due on the same tick.
          case (rpt_st)
            IDLE: begin
              if (acc_press && (REPEAT_EN != 0)) begin
                rpt_st  <= DELAY;
                rpt_cnt <= '0;
              end
            end
            default: begin
              if (acc_rel) begin
                rpt_st  <= IDLE;
                rpt_cnt <= '0;
              end else if (rpt_next == rpt_thr) begin
                press_q <= 1'b1;
                rpt_q   <= 1'b1;
                rpt_cnt <= '0;
                rpt_st  <= REPEAT;
              end else begin
                rpt_cnt <= rpt_next;
              end
            end
          endcase
        end
      end
    end

    assign key_state[g]   = state_q;
    assign key_press[g]   = press_q;
    assign key_repeat[g]  = rpt_q;
    assign key_release[g] = rel_q;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
`timescale 1ns/1ps
// Directed bench for key_debounce_array: active-high and active-low instances side by side.
module tb_key_debounce_array;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] key_in = 4'b0000;
  logic [3:0] key_in_n = 4'b1111;
  logic [3:0] st, pr, rp, rl;
  logic [3:0] st2, pr2, rp2, rl2;
  logic       tk, tk2;
  int checks = 0, errors = 0, stray = 0, timeouts = 0, cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_array #(
    .N_KEYS(4), .SAMPLE_DIV(10), .STABLE_CNT(3), .ACTIVE_LOW(0),
    .REPEAT_EN(1), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .CLK_50M(clk), .RSTn(rstn), .key_in(key_in),
    .key_state(st), .key_press(pr), .key_repeat(rp), .key_release(rl),
    .sample_tick(tk)
  );

  key_debounce_array #(
    .N_KEYS(4), .SAMPLE_DIV(10), .STABLE_CNT(3), .ACTIVE_LOW(1),
    .REPEAT_EN(1), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut_n (
    .CLK_50M(clk), .RSTn(rstn), .key_in(key_in_n),
    .key_state(st2), .key_press(pr2), .key_repeat(rp2), .key_release(rl2),
    .sample_tick(tk2)
  );

  // Advance to the negedge of the next sample_tick cycle, noting pulses seen off-tick.
  task automatic next_tick();
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tk) found = 1'b1;
      else if ((pr | rp | rl | pr2 | rp2 | rl2) != 4'b0000) stray++;
    end
    if (!found) timeouts++;
  endtask

  task automatic test_reset();
    int last = -1, ticks = 0, bad_gap = 0, nonzero = 0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({st, pr, rp, rl, tk, st2, pr2, rp2, rl2, tk2} !== 34'b0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", {st, pr, rp, rl, tk, st2, pr2, rp2, rl2, tk2});
    end
    rstn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tk) begin
        if (last >= 0 && cyc - last != 10) bad_gap++;
        last = cyc;
        ticks++;
      end
      if ({st, pr, rp, rl, st2, pr2, rp2, rl2} != 32'b0) nonzero++;
    end
    checks++;
    if (ticks !== 20) begin
      errors++;
      $display("FAIL tick_count got %0d expected 20", ticks);
    end
    checks++;
    if (bad_gap !== 0) begin
      errors++;
      $display("FAIL tick_period irregular_gaps %0d expected 0", bad_gap);
    end
    checks++;
    if (nonzero !== 0) begin
      errors++;
      $display("FAIL idle_outputs nonzero_cycles %0d expected 0", nonzero);
    end
  endtask

  task automatic test_clean_press();
    logic [15:0] exp;
    stray = 0;
    next_tick();
    key_in[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      next_tick();
      exp = {(t == 3) ? 4'b0001 : 4'b0000, 4'b0000,
             (t == 7) ? 4'b0001 : 4'b0000,
             (t >= 3 && t <= 6) ? 4'b0001 : 4'b0000};
      checks++;
      if ({pr, rp, rl, st} !== exp) begin
        errors++;
        $display("FAIL clean_press t=%0d got %b expected %b", t, {pr, rp, rl, st}, exp);
      end
      if (t == 4) key_in[0] = 1'b0;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL clean_press_offtick got %0d expected 0", stray);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] exp;
    stray = 0;
    next_tick();
    key_in[1] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      next_tick();
      exp = {(t == 6) ? 4'b0010 : 4'b0000, 4'b0000,
             (t == 10) ? 4'b0010 : 4'b0000,
             (t >= 6 && t <= 9) ? 4'b0010 : 4'b0000};
      checks++;
      if ({pr, rp, rl, st} !== exp) begin
        errors++;
        $display("FAIL bounce t=%0d got %b expected %b", t, {pr, rp, rl, st}, exp);
      end
      if (t == 2) key_in[1] = 1'b0;
      if (t == 3) key_in[1] = 1'b1;
      if (t == 7) key_in[1] = 1'b0;
    end
  endtask

  task automatic test_repeat();
    logic [15:0] exp;
    bit rpt_tick;
    stray = 0;
    next_tick();
    key_in[2] = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      next_tick();
      rpt_tick = (t == 8 || t == 10 || t == 12 || t == 14);
      exp = {(t == 3 || rpt_tick) ? 4'b0100 : 4'b0000,
             rpt_tick ? 4'b0100 : 4'b0000,
             (t == 15) ? 4'b0100 : 4'b0000,
             (t >= 3 && t <= 14) ? 4'b0100 : 4'b0000};
      checks++;
      if ({pr, rp, rl, st} !== exp) begin
        errors++;
        $display("FAIL repeat t=%0d got %b expected %b", t, {pr, rp, rl, st}, exp);
      end
      if (t == 12) key_in[2] = 1'b0;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL repeat_offtick got %0d expected 0", stray);
    end
  endtask

  task automatic test_active_low();
    logic [15:0] exp;
    next_tick();
    key_in_n = 4'b0110;
    for (int t = 1; t <= 7; t++) begin
      next_tick();
      exp = {(t == 3) ? 4'b1001 : 4'b0000, 4'b0000,
             (t == 6) ? 4'b1001 : 4'b0000,
             (t >= 3 && t <= 5) ? 4'b1001 : 4'b0000};
      checks++;
      if ({pr2, rp2, rl2, st2} !== exp) begin
        errors++;
        $display("FAIL active_low t=%0d got %b expected %b", t, {pr2, rp2, rl2, st2}, exp);
      end
      if (t == 3) begin
        checks++;
        if ({pr, rl, st} !== 12'b0) begin
          errors++;
          $display("FAIL active_high_quiet got %b expected 0", {pr, rl, st});
        end
        key_in_n = 4'b1111;
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [15:0] exp;
    next_tick();
    key_in[1] = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      next_tick();
      if (t == 8) begin
        checks++;
        if ({pr, rp} !== 8'b0010_0010) begin
          errors++;
          $display("FAIL pre_reset_repeat got %b expected 00100010", {pr, rp});
        end
      end
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({st, pr, rp, rl, tk, st2, pr2, rp2, rl2, tk2} !== 34'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h expected 0", {st, pr, rp, rl, tk, st2, pr2, rp2, rl2, tk2});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      next_tick();
      exp = {(t == 3 || t == 8) ? 4'b0010 : 4'b0000,
             (t == 8) ? 4'b0010 : 4'b0000,
             4'b0000,
             (t >= 3) ? 4'b0010 : 4'b0000};
      checks++;
      if ({pr, rp, rl, st} !== exp) begin
        errors++;
        $display("FAIL post_reset t=%0d got %b expected %b", t, {pr, rp, rl, st}, exp);
      end
    end
    key_in[1] = 1'b0;
    repeat (4) next_tick();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_active_low();
    test_reset_mid_repeat();
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL tick_timeout got %0d expected 0", timeouts);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
